// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing
//  Description : 640x480@60 VGA timing generator. Divides clk down to a pixel
//                tick, runs horizontal/vertical counters, publishes the pixel
//                coordinate, and registers blanked colour plus active-low
//                syncs toward the DAC. Emits a one-clk end-of-frame strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] red_in,
    input  logic [3:0] green_in,
    input  logic [3:0] blue_in,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       frame_tick,
    output logic       Hsync,
    output logic       Vsync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] c_H_LAST     = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST     = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] c_V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] c_HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] c_HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] c_VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] c_VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [c_DIV_W-1:0] r_div_cnt;
    logic [9:0]         r_h_cnt;
    logic [9:0]         r_v_cnt;
    logic               r_hsync;
    logic               r_vsync;
    logic [11:0]        r_rgb;

    logic w_tick;
    logic w_h_last;
    logic w_v_last;
    logic w_video_on;
    logic w_hs_active;
    logic w_vs_active;

    // Pixel tick and counter/window decodes, all from the current counter state
    assign w_tick      = (r_div_cnt == c_DIV_LAST);
    assign w_h_last    = (r_h_cnt == c_H_LAST);
    assign w_v_last    = (r_v_cnt == c_V_LAST);
    assign w_video_on  = (r_h_cnt < c_H_VIS) && (r_v_cnt < c_V_VIS);
    assign w_hs_active = (r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END);
    assign w_vs_active = (r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END);

    // Clock divider: free-running 0..CLK_DIV-1, tick on the last count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Raster counters: advance one pixel per tick, line advances on h wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_tick) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? 10'd0 : (r_v_cnt + 10'd1);
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    // Sync and colour registers sample the pre-increment position on each tick,
    // so a pixel's colour and its syncs reach the connector together
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= 12'h000;
        end else if (w_tick) begin
            r_hsync <= ~w_hs_active;
            r_vsync <= ~w_vs_active;
            r_rgb   <= w_video_on ? {red_in, green_in, blue_in} : 12'h000;
        end
    end

    assign pixel_x    = r_h_cnt;
    assign pixel_y    = r_v_cnt;
    assign video_on   = w_video_on;
    // Gated by reset so no strobe can escape while the counters are being cleared
    assign frame_tick = ~reset & w_tick & w_h_last & w_v_last;
    assign Hsync      = r_hsync;
    assign Vsync      = r_vsync;
    assign red        = r_rgb[11:8];
    assign green      = r_rgb[7:4];
    assign blue       = r_rgb[3:0];

endmodule
`default_nettype wire
